// File: rtl/commit_queue_pkg.sv
//------------------------------------------------------------------------------
// commit_queue_pkg
// Shared types and sizing for the in-order commit queue.
//   commit_entry_t : scoreboard entry handed to the commit stage
//   TRANS_ID_BITS  : width of a transaction id (= queue index)
//   sel_bits()     : index width for a set of N ports (never below 1)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package commit_queue_pkg;

   localparam int CQ_NR_ENTRIES      = 8;
   localparam int CQ_NR_COMMIT_PORTS = 2;
   localparam int CQ_NR_WB_PORTS     = 4;
   localparam int XLEN               = 64;
   localparam int VLEN               = 64;
   localparam int TRANS_ID_BITS      = $clog2(CQ_NR_ENTRIES);

   typedef struct packed {
      logic [VLEN-1:0] pc;
      logic [3:0]      fu;
      logic [7:0]      op;
      logic [4:0]      rd;
      logic [XLEN-1:0] result;
      logic            ex_valid;
      logic [XLEN-1:0] ex_cause;
   } commit_entry_t;

   function automatic int sel_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/commit_queue_wb_match.sv
//------------------------------------------------------------------------------
// commit_queue_wb_match
// Resolves which writeback port (if any) targets one queue entry. When several
// ports carry the same id in a cycle, the lowest port index wins.
// Ports:
//   wb_valid    in  per-port writeback strobe
//   wb_trans_id in  per-port target id
//   hit         out some valid port targets this entry
//   sel         out winning port index (meaningful only when hit)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module commit_queue_wb_match
   import commit_queue_pkg::*;
#(
   parameter int NR_WB_PORTS = 4,
   parameter int TID_W       = 3,
   parameter int ENTRY_IDX   = 0,
   localparam int SEL_W      = sel_bits(NR_WB_PORTS)
) (
   input  logic [NR_WB_PORTS-1:0] wb_valid,
   input  logic [TID_W-1:0]       wb_trans_id [NR_WB_PORTS],
   output logic                   hit,
   output logic [SEL_W-1:0]       sel
);

   localparam logic [TID_W-1:0] IDX = TID_W'(ENTRY_IDX);

   // Scan from the highest port down so the lowest matching port is the
   // last one assigned.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
         if (wb_valid[p] && (wb_trans_id[p] == IDX)) begin
            hit = 1'b1;
            sel = SEL_W'(p);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/commit_queue.sv
//------------------------------------------------------------------------------
// commit_queue
// In-order commit queue: allocates one entry per issued instruction, records
// execute writebacks by transaction id, presents the oldest completed entries
// in program order and retires the ones the commit stage acknowledges.
// Optional feature macro: COMMIT_QUEUE_WB_BYPASS_EN - forwards same-cycle
// writebacks to the presented head entries (removes one cycle of latency).
// Ports:
//   clk_i, rst_i (sync, active high), flush_i (discard all entries)
//   issue_valid_i/issue_ready_o/issue_entry_i/issue_trans_id_o : allocation
//   wb_valid_i/wb_trans_id_i/wb_result_i/wb_ex_valid_i/wb_ex_cause_i : writeback
//   commit_valid_o/commit_entry_o/commit_ack_i : in-order commit interface
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module commit_queue
   import commit_queue_pkg::*;
#(
   parameter int NR_ENTRIES      = CQ_NR_ENTRIES,
   parameter int NR_COMMIT_PORTS = CQ_NR_COMMIT_PORTS,
   parameter int NR_WB_PORTS     = CQ_NR_WB_PORTS,
   localparam int TID_W          = $clog2(NR_ENTRIES)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       issue_valid_i,
   output logic                       issue_ready_o,
   input  commit_entry_t              issue_entry_i,
   output logic [TID_W-1:0]           issue_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]     wb_valid_i,
   input  logic [TID_W-1:0]           wb_trans_id_i [NR_WB_PORTS],
   input  logic [XLEN-1:0]            wb_result_i   [NR_WB_PORTS],
   input  logic [NR_WB_PORTS-1:0]     wb_ex_valid_i,
   input  logic [XLEN-1:0]            wb_ex_cause_i [NR_WB_PORTS],
   output logic [NR_COMMIT_PORTS-1:0] commit_valid_o,
   output commit_entry_t              commit_entry_o [NR_COMMIT_PORTS],
   input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i
);

   localparam int SEL_W = sel_bits(NR_WB_PORTS);
   localparam int CNT_W = TID_W + 1;
   localparam int POP_W = $clog2(NR_COMMIT_PORTS + 1);

   commit_entry_t               mem [NR_ENTRIES];
   logic [NR_ENTRIES-1:0]       busy;
   logic [NR_ENTRIES-1:0]       done;
   logic [TID_W-1:0]            head;
   logic [TID_W-1:0]            tail;
   logic [CNT_W-1:0]            count;

   logic [NR_ENTRIES-1:0]       wb_hit;
   logic [NR_ENTRIES-1:0]       wb_take;
   logic [SEL_W-1:0]            wb_sel [NR_ENTRIES];
   logic [NR_ENTRIES-1:0]       pop_clr;
   logic                        alloc;
   logic [NR_COMMIT_PORTS-1:0]  ready_vec;
   logic [NR_COMMIT_PORTS-1:0]  pop;
   logic [POP_W-1:0]            pops;

   // Ready depends only on the registered count: a pop in the same cycle
   // never frees space for an allocation.
   assign issue_ready_o    = (count != CNT_W'(NR_ENTRIES));
   assign alloc            = issue_valid_i & issue_ready_o;
   assign issue_trans_id_o = tail;

   // Per-entry writeback select. Writebacks to idle entries, or to the entry
   // being allocated this cycle, are dropped.
   generate
      for (genvar e = 0; e < NR_ENTRIES; e++) begin : g_entry
         commit_queue_wb_match #(
            .NR_WB_PORTS (NR_WB_PORTS),
            .TID_W       (TID_W),
            .ENTRY_IDX   (e)
         ) u_wb_match (
            .wb_valid    (wb_valid_i),
            .wb_trans_id (wb_trans_id_i),
            .hit         (wb_hit[e]),
            .sel         (wb_sel[e])
         );
         assign wb_take[e] = wb_hit[e] & busy[e] & ~(alloc & (tail == TID_W'(e)));
      end
   endgenerate

   // Presentation of head+i.
   generate
      for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_port
         logic [TID_W-1:0] idx;
         logic             ready;
         commit_entry_t    ent;

         assign idx = head + TID_W'(i);

         always_comb begin
            ent   = mem[idx];
            ready = busy[idx] & done[idx];
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
            if (wb_take[idx]) begin
               ready      = 1'b1;
               ent.result = wb_result_i[wb_sel[idx]];
               if (wb_ex_valid_i[wb_sel[idx]]) begin
                  ent.ex_valid = 1'b1;
                  ent.ex_cause = wb_ex_cause_i[wb_sel[idx]];
               end
            end
`endif
         end

         assign ready_vec[i]      = ready;
         assign commit_entry_o[i] = ent;
      end
   endgenerate

   // Valid is gated in order; only a leading run of acked valid ports pops.
   always_comb begin
      commit_valid_o    = '0;
      pop               = '0;
      commit_valid_o[0] = ready_vec[0];
      pop[0]            = ready_vec[0] & commit_ack_i[0];
      for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
         commit_valid_o[i] = commit_valid_o[i-1] & ready_vec[i];
         pop[i]            = pop[i-1] & commit_valid_o[i] & commit_ack_i[i];
      end
   end

   always_comb begin
      pops    = '0;
      pop_clr = '0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         if (pop[i]) begin
            pops                           = pops + POP_W'(1);
            pop_clr[head + TID_W'(i)]      = 1'b1;
         end
      end
   end

   // A popped entry is never the allocation target (that would need a full
   // queue, which blocks allocation), so clear and allocate cannot collide.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         busy  <= '0;
         done  <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int e = 0; e < NR_ENTRIES; e++) begin
            if (wb_take[e]) begin
               done[e]       <= 1'b1;
               mem[e].result <= wb_result_i[wb_sel[e]];
               if (wb_ex_valid_i[wb_sel[e]]) begin
                  mem[e].ex_valid <= 1'b1;
                  mem[e].ex_cause <= wb_ex_cause_i[wb_sel[e]];
               end
            end
            if (pop_clr[e]) begin
               busy[e] <= 1'b0;
               done[e] <= 1'b0;
            end
         end
         if (alloc) begin
            mem[tail]  <= issue_entry_i;
            busy[tail] <= 1'b1;
            done[tail] <= issue_entry_i.ex_valid;
            tail       <= tail + TID_W'(1);
         end
         head  <= head + TID_W'(pops);
         count <= count + CNT_W'(alloc) - CNT_W'(pops);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_commit_queue.sv
//------------------------------------------------------------------------------
// tb_commit_queue
// Self-checking bench for commit_queue. A program-order id list plus per-id
// completion state serves as the reference; directed scenarios are followed
// by a randomized run. Honors COMMIT_QUEUE_WB_BYPASS_EN for expected latency.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_commit_queue;
   import commit_queue_pkg::*;

   localparam int NE = 8;
   localparam int NC = 2;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          issue_valid;
   logic          issue_ready;
   commit_entry_t issue_entry;
   logic [2:0]    issue_trans_id;
   logic [NW-1:0] wb_valid;
   logic [2:0]    wb_trans_id [NW];
   logic [63:0]   wb_result   [NW];
   logic [NW-1:0] wb_ex_valid;
   logic [63:0]   wb_ex_cause [NW];
   logic [NC-1:0] commit_valid;
   commit_entry_t commit_entry [NC];
   logic [NC-1:0] commit_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   commit_queue dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_i          (flush),
      .issue_valid_i    (issue_valid),
      .issue_ready_o    (issue_ready),
      .issue_entry_i    (issue_entry),
      .issue_trans_id_o (issue_trans_id),
      .wb_valid_i       (wb_valid),
      .wb_trans_id_i    (wb_trans_id),
      .wb_result_i      (wb_result),
      .wb_ex_valid_i    (wb_ex_valid),
      .wb_ex_cause_i    (wb_ex_cause),
      .commit_valid_o   (commit_valid),
      .commit_entry_o   (commit_entry),
      .commit_ack_i     (commit_ack)
   );

   // Reference: ids in program order, per-id payload and completion.
   int            q[$];
   int            next_id = 0;
   commit_entry_t m_ent  [NE];
   bit            m_done [NE];

   function automatic int first_wb(input int id);
      for (int p = 0; p < NW; p++)
         if (wb_valid[p] && (int'(wb_trans_id[p]) == id)) return p;
      return -1;
   endfunction

   function automatic bit port_ready(input int i);
      int p;
      if (i >= q.size()) return 1'b0;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      p = first_wb(q[i]);
      if (p >= 0) return 1'b1;
`else
      p = 0;
`endif
      return m_done[q[i]];
   endfunction

   function automatic logic [NC-1:0] exp_valid();
      logic [NC-1:0] v = '0;
      for (int i = 0; i < NC; i++) begin
         if (!port_ready(i)) break;
         v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic commit_entry_t exp_entry(input int i);
      commit_entry_t e = m_ent[q[i]];
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      int p = first_wb(q[i]);
      if (p >= 0) begin
         e.result = wb_result[p];
         if (wb_ex_valid[p]) begin
            e.ex_valid = 1'b1;
            e.ex_cause = wb_ex_cause[p];
         end
      end
`endif
      return e;
   endfunction

   // Advance the reference with the inputs currently applied, then clock.
   task automatic tick();
      logic [NC-1:0] v;
      int pops;
      int p;
      bit al;
      v    = exp_valid();
      pops = 0;
      if (rst || flush) begin
         q.delete();
         next_id = 0;
      end else begin
         al = issue_valid && (q.size() < NE);
         for (int i = 0; i < NC; i++)
            if (v[i] && commit_ack[i] && (pops == i)) pops++;
         foreach (q[k]) begin
            p = first_wb(q[k]);
            if (p >= 0) begin
               m_done[q[k]]        = 1'b1;
               m_ent[q[k]].result  = wb_result[p];
               if (wb_ex_valid[p]) begin
                  m_ent[q[k]].ex_valid = 1'b1;
                  m_ent[q[k]].ex_cause = wb_ex_cause[p];
               end
            end
         end
         repeat (pops) void'(q.pop_front());
         if (al) begin
            q.push_back(next_id);
            m_ent[next_id]  = issue_entry;
            m_done[next_id] = issue_entry.ex_valid;
            next_id         = (next_id + 1) % NE;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush       = 1'b0;
      issue_valid = 1'b0;
      issue_entry = '0;
      wb_valid    = '0;
      wb_ex_valid = '0;
      commit_ack  = '0;
      for (int p = 0; p < NW; p++) begin
         wb_trans_id[p] = '0;
         wb_result[p]   = '0;
         wb_ex_cause[p] = '0;
      end
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc_n(input int n, input logic [63:0] pc_base);
      for (int k = 0; k < n; k++) begin
         idle();
         issue_valid    = 1'b1;
         issue_entry.pc = pc_base + 64'(4 * k);
         issue_entry.rd = 5'(k + 1);
         tick();
      end
      idle();
   endtask

   task automatic set_wb(input int p, input int id, input logic [63:0] res);
      wb_valid[p]    = 1'b1;
      wb_trans_id[p] = 3'(id);
      wb_result[p]   = res;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
      checks++;
      if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", commit_valid); end
      checks++;
      if (issue_trans_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", issue_trans_id); end
   endtask

   task automatic test_basic();
      do_reset();
      issue_valid    = 1'b1;
      issue_entry.pc = 64'h8000_0000;
      #1;
      checks++;
      if (issue_trans_id !== 3'd0) begin errors++; $display("FAIL basic_id: got %0d want 0", issue_trans_id); end
      tick();
      idle();
      set_wb(0, 0, 64'h5);
      #1;
      checks++;
      if (commit_valid !== exp_valid()) begin errors++; $display("FAIL basic_wb_cycle_valid: got %b want %b", commit_valid, exp_valid()); end
      tick();
      idle();
      #1;
      checks++;
      if (commit_valid !== 2'b01) begin errors++; $display("FAIL basic_valid: got %b want 01", commit_valid); end
      checks++;
      if (commit_entry[0].result !== 64'h5 || commit_entry[0].pc !== 64'h8000_0000) begin
         errors++; $display("FAIL basic_entry: got res %h pc %h want 5 80000000", commit_entry[0].result, commit_entry[0].pc);
      end
      commit_ack = 2'b01;
      tick();
      idle();
      #1;
      checks++;
      if (issue_ready !== 1'b1 || commit_valid !== 2'b00) begin
         errors++; $display("FAIL basic_retire: got ready %b valid %b want 1 00", issue_ready, commit_valid);
      end
   endtask

   task automatic test_full_wrap();
      do_reset();
      alloc_n(8, 64'h1000);
      checks++;
      if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", issue_ready); end
      set_wb(0, 0, 64'h10);
      set_wb(1, 1, 64'h11);
      tick();
      idle();
      commit_ack  = 2'b11;
      issue_valid = 1'b1;
      #1;
      checks++;
      if (commit_valid !== 2'b11 || issue_ready !== 1'b0) begin
         errors++; $display("FAIL full_pop_cycle: got valid %b ready %b want 11 0", commit_valid, issue_ready);
      end
      tick();
      idle();
      #1;
      checks++;
      if (issue_ready !== 1'b1 || issue_trans_id !== 3'd0 || commit_valid !== 2'b00) begin
         errors++; $display("FAIL full_after_pop: got ready %b id %0d valid %b want 1 0 00", issue_ready, issue_trans_id, commit_valid);
      end
      alloc_n(2, 64'h2000);
      checks++;
      if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_refill: got ready %b want 0", issue_ready); end
   endtask

   task automatic test_inorder();
      do_reset();
      alloc_n(2, 64'h3000);
      set_wb(0, 1, 64'h21);
      tick();
      idle();
      #1;
      checks++;
      if (commit_valid !== 2'b00) begin errors++; $display("FAIL inorder_gate: got %b want 00", commit_valid); end
      set_wb(0, 0, 64'h20);
      #1;
      checks++;
      if (commit_valid !== exp_valid()) begin errors++; $display("FAIL inorder_wb_cycle: got %b want %b", commit_valid, exp_valid()); end
      tick();
      idle();
      #1;
      checks++;
      if (commit_valid !== 2'b11) begin errors++; $display("FAIL inorder_both: got %b want 11", commit_valid); end
   endtask

   task automatic test_exception();
      do_reset();
      issue_valid          = 1'b1;
      issue_entry.pc       = 64'h4000;
      issue_entry.ex_valid = 1'b1;
      issue_entry.ex_cause = 64'hC;
      tick();
      idle();
      #1;
      checks++;
      if (commit_valid[0] !== 1'b1 || commit_entry[0].ex_cause !== 64'hC || commit_entry[0].ex_valid !== 1'b1) begin
         errors++; $display("FAIL exc_fetch: got valid %b ex %b cause %h want 1 1 c", commit_valid[0], commit_entry[0].ex_valid, commit_entry[0].ex_cause);
      end
      alloc_n(3, 64'h4004);
      set_wb(0, 3, 64'hAAAA);
      set_wb(2, 3, 64'hBBBB);
      set_wb(1, 1, 64'h1111);
      set_wb(3, 2, 64'h2222);
      tick();
      idle();
      commit_ack = 2'b11;
      #1;
      checks++;
      if (commit_valid !== 2'b11) begin errors++; $display("FAIL exc_pair_valid: got %b want 11", commit_valid); end
      tick();
      idle();
      #1;
      checks++;
      if (commit_valid !== 2'b11 || commit_entry[1].result !== 64'hAAAA) begin
         errors++; $display("FAIL wb_priority: got valid %b res %h want 11 aaaa", commit_valid, commit_entry[1].result);
      end
   endtask

   task automatic test_ack_pattern();
      do_reset();
      alloc_n(3, 64'h100);
      set_wb(0, 0, 64'h1);
      set_wb(1, 1, 64'h2);
      set_wb(2, 2, 64'h3);
      tick();
      idle();
      commit_ack = 2'b01;
      #1;
      checks++;
      if (commit_valid !== 2'b11) begin errors++; $display("FAIL ack_valid: got %b want 11", commit_valid); end
      tick();
      idle();
      #1;
      checks++;
      if (commit_entry[0].pc !== 64'h104) begin errors++; $display("FAIL ack_pop1: got pc %h want 104", commit_entry[0].pc); end
      commit_ack = 2'b10;
      tick();
      idle();
      #1;
      checks++;
      if (commit_entry[0].pc !== 64'h104 || commit_valid !== 2'b11) begin
         errors++; $display("FAIL ack_pop0: got pc %h valid %b want 104 11", commit_entry[0].pc, commit_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      alloc_n(5, 64'h500);
      set_wb(0, 0, 64'h50);
      tick();
      idle();
      flush       = 1'b1;
      issue_valid = 1'b1;
      commit_ack  = 2'b01;
      tick();
      idle();
      #1;
      checks++;
      if (issue_ready !== 1'b1 || commit_valid !== 2'b00 || issue_trans_id !== 3'd0) begin
         errors++; $display("FAIL flush: got ready %b valid %b id %0d want 1 00 0", issue_ready, commit_valid, issue_trans_id);
      end
      alloc_n(3, 64'h600);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (issue_trans_id !== 3'd0 || commit_valid !== 2'b00 || issue_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset: got id %0d valid %b ready %b want 0 00 1", issue_trans_id, commit_valid, issue_ready);
      end
   endtask

   task automatic test_bypass();
      do_reset();
      alloc_n(1, 64'h700);
      set_wb(0, 0, 64'h77);
      #1;
      checks++;
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
      if (commit_valid[0] !== 1'b1 || commit_entry[0].result !== 64'h77) begin
         errors++; $display("FAIL bypass_same_cycle: got valid %b res %h want 1 77", commit_valid[0], commit_entry[0].result);
      end
`else
      if (commit_valid[0] !== 1'b0) begin
         errors++; $display("FAIL wb_latency: got valid %b want 0", commit_valid[0]);
      end
`endif
      tick();
      idle();
   endtask

   task automatic test_random();
      logic [NC-1:0] v;
      commit_entry_t e;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         idle();
         issue_valid          = ($urandom_range(0, 99) < 60);
         issue_entry.pc       = {$urandom, $urandom};
         issue_entry.fu       = 4'($urandom);
         issue_entry.op       = 8'($urandom);
         issue_entry.rd       = 5'($urandom);
         issue_entry.result   = {$urandom, $urandom};
         issue_entry.ex_valid = ($urandom_range(0, 9) == 0);
         issue_entry.ex_cause = 64'($urandom_range(0, 15));
         for (int p = 0; p < NW; p++) begin
            wb_valid[p]    = ($urandom_range(0, 1) == 1);
            wb_trans_id[p] = 3'($urandom_range(0, 7));
            wb_result[p]   = {$urandom, $urandom};
            wb_ex_valid[p] = ($urandom_range(0, 7) == 0);
            wb_ex_cause[p] = 64'($urandom_range(0, 15));
         end
         commit_ack = 2'($urandom_range(0, 3));
         flush      = ($urandom_range(0, 49) == 0);
         #1;
         v = exp_valid();
         checks++;
         if (issue_ready !== (q.size() != NE)) begin errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, issue_ready, (q.size() != NE)); end
         checks++;
         if (issue_trans_id !== 3'(next_id)) begin errors++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, issue_trans_id, next_id); end
         checks++;
         if (commit_valid !== v) begin errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, commit_valid, v); end
         for (int i = 0; i < NC; i++) begin
            if (v[i]) begin
               e = exp_entry(i);
               checks++;
               if (commit_entry[i] !== e) begin
                  errors++; $display("FAIL rnd_entry%0d c=%0d: got %h want %h", i, c, commit_entry[i], e);
               end
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_full_wrap();
      test_inorder();
      test_exception();
      test_ack_pattern();
      test_flush();
      test_bypass();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
